// File: rtl/io_tx_buffer.sv
// io_tx_buffer: memory-mapped UART transmitter with a byte FIFO, back-pressure, halt latch and overflow flag.
// Define IO_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module io_tx_buffer #(
    parameter int DEPTH_WIDTH = 4,
    parameter int FULL_MARGIN = 2,
    parameter int BAUD_DIV    = 868
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic        io_buffer_full,
    output logic        uart_tx,
    output logic        sim_halt,
    output logic        overflow_err
);
    localparam int DEPTH  = 1 << DEPTH_WIDTH;
    localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [DEPTH_WIDTH:0]   COUNT_MAX  = (DEPTH_WIDTH + 1)'(DEPTH);
    localparam logic [DEPTH_WIDTH:0]   FULL_LEVEL = (DEPTH_WIDTH + 1)'(DEPTH - FULL_MARGIN);
    localparam logic [DEPTH_WIDTH:0]   COUNT_ONE  = (DEPTH_WIDTH + 1)'(1);
    localparam logic [DEPTH_WIDTH-1:0] PTR_ONE    = DEPTH_WIDTH'(1);
    localparam logic [BAUD_W-1:0]      BAUD_LAST  = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0]      BAUD_ONE   = BAUD_W'(1);

`ifdef IO_TX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_t;
`endif

    tx_state_t              state;
    tx_state_t              state_next;
    logic [7:0]             fifo_mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [DEPTH_WIDTH:0]   count;
    logic [7:0]             data_reg;
    logic [2:0]             bit_idx;
    logic [BAUD_W-1:0]      baud_cnt;
    logic                   io_sel;
    logic                   push_req;
    logic                   halt_req;
    logic                   push_ok;
    logic                   pop;
    logic                   bit_end;
    logic                   tx_bit;
    logic                   unused_addr_bits;

    // Only bits [17:16] and [2:0] take part in the decode.
    assign unused_addr_bits = ^{mem_a[31:18], mem_a[15:3]};

    assign io_sel   = rdy_in && mem_wr && (mem_a[17:16] == 2'b11);
    assign push_req = io_sel && (mem_a[2:0] == 3'd0);
    assign halt_req = io_sel && (mem_a[2:0] == 3'd4);
    assign pop      = (state == ST_IDLE) && (count != '0);
    assign push_ok  = push_req && ((count != COUNT_MAX) || pop);
    assign bit_end  = (baud_cnt == BAUD_LAST);

    assign io_buffer_full = (count >= FULL_LEVEL);

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= mem_dout;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
            sim_halt     <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_ok && !pop) begin
                count <= count + COUNT_ONE;
            end else if (pop && !push_ok) begin
                count <= count - COUNT_ONE;
            end
            if (push_req && !push_ok) begin
                overflow_err <= 1'b1;
            end
            if (halt_req) begin
                sim_halt <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (count != '0) state_next = ST_START;
            ST_START:  if (bit_end) state_next = ST_DATA;
`ifdef IO_TX_PARITY_EN
            ST_DATA:   if (bit_end && (bit_idx == 3'd7)) state_next = ST_PARITY;
            ST_PARITY: if (bit_end) state_next = ST_STOP;
`else
            ST_DATA:   if (bit_end && (bit_idx == 3'd7)) state_next = ST_STOP;
`endif
            ST_STOP:   if (bit_end) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Every active state ends a bit at bit_end, so the baud counter restarts there.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            data_reg <= '0;
        end else begin
            if (pop) begin
                data_reg <= fifo_mem[rd_ptr];
                bit_idx  <= '0;
            end else if ((state == ST_DATA) && bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if ((state == ST_IDLE) || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BAUD_ONE;
            end
        end
    end

    always_comb begin
        tx_bit = 1'b1;
        case (state)
            ST_START:  tx_bit = 1'b0;
            ST_DATA:   tx_bit = data_reg[bit_idx];
`ifdef IO_TX_PARITY_EN
            ST_PARITY: tx_bit = ^data_reg;
`endif
            default:   tx_bit = 1'b1;
        endcase
    end

    // Registered line driver keeps the serial output glitch-free and idles it high on reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            uart_tx <= 1'b1;
        end else begin
            uart_tx <= tx_bit;
        end
    end
endmodule

// File: tb/tb_io_tx_buffer.sv
// tb_io_tx_buffer: directed scenarios for io_tx_buffer with a queue/frame-timeline reference model
// and a line-level UART receiver; BAUD_DIV=4, depth 16.
module tb_io_tx_buffer;
    localparam int B = 4;
    localparam int D = 16;
`ifdef IO_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME = FRAME_BITS * B;

    logic        clk;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        uart_tx;
    logic        sim_halt;
    logic        overflow_err;

    int n_compared = 0;
    int n_mismatch = 0;
    logic check_en = 1'b0;

    io_tx_buffer #(.DEPTH_WIDTH(4), .FULL_MARGIN(2), .BAUD_DIV(B)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
        .mem_dout(mem_dout), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
        .uart_tx(uart_tx), .sim_halt(sim_halt), .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a byte queue plus the position inside the frame being sent.
    logic [7:0] mq[$];
    logic [7:0] sent_log[$];
    logic [7:0] m_cur = 8'h00;
    int   m_pos = FRAME;
    int   m_drops = 0;
    logic m_busy, m_pop, m_io, m_push, m_halt;
    logic exp_tx = 1'b1, exp_full = 1'b0, exp_halt = 1'b0, exp_ovf = 1'b0;
    logic model_in_reset = 1'b0;

    function automatic logic frame_bit(input logic [7:0] b, input int p);
        int k;
        k = p / B;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef IO_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        model_in_reset = rst_in;
        if (rst_in) begin
            mq.delete();
            m_pos = FRAME;
            exp_tx = 1'b1; exp_full = 1'b0; exp_halt = 1'b0; exp_ovf = 1'b0;
        end else begin
            m_busy = (m_pos < FRAME);
            exp_tx = m_busy ? frame_bit(m_cur, m_pos) : 1'b1;
            m_pop  = !m_busy && (mq.size() > 0);
            m_io   = rdy_in && mem_wr && (mem_a[17:16] == 2'b11);
            m_push = m_io && (mem_a[2:0] == 3'd0);
            m_halt = m_io && (mem_a[2:0] == 3'd4);
            if (m_busy) m_pos++;
            if (m_pop) begin
                m_cur = mq.pop_front();
                m_pos = 0;
                sent_log.push_back(m_cur);
            end
            if (m_push) begin
                if (mq.size() < D) mq.push_back(mem_dout);
                else begin
                    exp_ovf = 1'b1;
                    m_drops++;
                end
            end
            if (m_halt) exp_halt = 1'b1;
            exp_full = (mq.size() >= D - 2);
        end
    end

    // Line-level receiver, sampling each bit mid-way; aborts on reset.
    logic [7:0] rx_log[$];
    logic [7:0] rx_byte = 8'h00;
    logic rx_busy = 1'b0;
    int   rx_t = 0;

    always @(negedge clk) begin
        if (model_in_reset) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (uart_tx == 1'b0) begin
                rx_busy = 1'b1;
                rx_t = 0;
                rx_byte = 8'h00;
            end
        end else begin
            rx_t++;
            if ((rx_t % B == B / 2) && (rx_t / B >= 1) && (rx_t / B <= 8))
                rx_byte[rx_t / B - 1] = uart_tx;
            if (rx_t == B * (FRAME_BITS - 1) + B / 2) begin
                rx_busy = 1'b0;
                rx_log.push_back(rx_byte);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("uart_tx", {31'd0, uart_tx}, {31'd0, exp_tx});
            checkOutput("io_buffer_full", {31'd0, io_buffer_full}, {31'd0, exp_full});
            checkOutput("sim_halt", {31'd0, sim_halt}, {31'd0, exp_halt});
            checkOutput("overflow_err", {31'd0, overflow_err}, {31'd0, exp_ovf});
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Drives one bus cycle; returns in the cycle after the edge that sampled it.
    task automatic applyStimulus(input logic rdy, input logic wr, input logic [31:0] addr, input logic [7:0] data);
        rdy_in = rdy; mem_wr = wr; mem_a = addr; mem_dout = data;
        step();
        rdy_in = 1'b1; mem_wr = 1'b0; mem_a = 32'h0; mem_dout = 8'h00;
    endtask

    task automatic doReset();
        rst_in = 1'b1;
        step(2);
        rst_in = 1'b0;
        rx_log.delete();
        sent_log.delete();
        m_drops = 0;
        check_en = 1'b1;
        checkOutput("reset uart_tx", {31'd0, uart_tx}, 32'd1);
        checkOutput("reset io_buffer_full", {31'd0, io_buffer_full}, 32'd0);
        checkOutput("reset sim_halt", {31'd0, sim_halt}, 32'd0);
        checkOutput("reset overflow_err", {31'd0, overflow_err}, 32'd0);
    endtask

    task automatic waitIdle(input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            if ((m_pos >= FRAME) && (mq.size() == 0)) break;
            step();
        end
        if (i == limit) checkOutput("wait_idle timeout", 32'd0, 32'd1);
        step(3);
    endtask

    int frame41 [FRAME_BITS];

    initial begin
`ifdef IO_TX_PARITY_EN
        frame41 = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1};
`else
        frame41 = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
`endif
        rst_in = 1'b0; rdy_in = 1'b1; mem_wr = 1'b0; mem_a = 32'h0; mem_dout = 8'h00;
        step(2);

        $display("[TB] single byte 0x41");
        doReset();
        applyStimulus(1'b1, 1'b1, 32'h0003_0000, 8'h41);
        step();
        checkOutput("pre-start idle", {31'd0, uart_tx}, 32'd1);
        for (int k = 0; k < FRAME; k++) begin
            step();
            checkOutput("frame 0x41 bit", {31'd0, uart_tx}, frame41[k / B]);
        end
        waitIdle(200);
        checkOutput("rx count 0x41", rx_log.size(), 32'd1);
        if (rx_log.size() > 0) checkOutput("rx byte 0x41", {24'd0, rx_log[0]}, 32'h41);

        $display("[TB] ignored writes and halt");
        doReset();
        applyStimulus(1'b0, 1'b1, 32'h0003_0000, 8'h5A);
        applyStimulus(1'b1, 1'b1, 32'h0000_0010, 8'h33);
        step(60);
        checkOutput("ignored writes tx", {31'd0, uart_tx}, 32'd1);
        checkOutput("ignored writes rx", rx_log.size(), 32'd0);
        checkOutput("halt before", {31'd0, sim_halt}, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h0003_0004, 8'h00);
        checkOutput("halt set", {31'd0, sim_halt}, 32'd1);
        step(10);
        checkOutput("halt sticky", {31'd0, sim_halt}, 32'd1);

        $display("[TB] burst of 20 writes");
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h0003_0000, 8'(i));
            if (i == 13) checkOutput("full at count 13", {31'd0, io_buffer_full}, 32'd0);
            if (i == 14) checkOutput("full at count 14", {31'd0, io_buffer_full}, 32'd1);
            if (i == 16) checkOutput("no overflow at 17th", {31'd0, overflow_err}, 32'd0);
            if (i == 17) checkOutput("overflow at 18th", {31'd0, overflow_err}, 32'd1);
        end
        waitIdle(2000);
        checkOutput("model drops", m_drops, 32'd3);
        checkOutput("model sent count", sent_log.size(), 32'd17);
        checkOutput("rx count burst", rx_log.size(), 32'd17);
        for (int i = 0; i < 17; i++) begin
            if (i < rx_log.size()) checkOutput("rx burst byte", {24'd0, rx_log[i]}, i);
        end

        $display("[TB] push on the pop edge");
        doReset();
        applyStimulus(1'b1, 1'b1, 32'h0003_0000, 8'hA5);
        applyStimulus(1'b1, 1'b1, 32'h0003_0000, 8'h3C);
        step(41);
        checkOutput("gap cycle", {31'd0, uart_tx}, 32'd1);
        step();
        checkOutput("second start", {31'd0, uart_tx}, 32'd0);
        waitIdle(200);
        checkOutput("rx count pair", rx_log.size(), 32'd2);
        if (rx_log.size() == 2) begin
            checkOutput("rx pair byte0", {24'd0, rx_log[0]}, 32'hA5);
            checkOutput("rx pair byte1", {24'd0, rx_log[1]}, 32'h3C);
        end

        $display("[TB] reset during data bit 3");
        doReset();
        applyStimulus(1'b1, 1'b1, 32'h0003_0000, 8'h55);
        applyStimulus(1'b1, 1'b1, 32'h0003_0000, 8'h66);
        applyStimulus(1'b1, 1'b1, 32'h0003_0000, 8'h77);
        step(16);
        checkOutput("data bit 3 low", {31'd0, uart_tx}, 32'd0);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        checkOutput("abort tx high", {31'd0, uart_tx}, 32'd1);
        step(150);
        checkOutput("after abort tx", {31'd0, uart_tx}, 32'd1);
        checkOutput("after abort full", {31'd0, io_buffer_full}, 32'd0);
        checkOutput("after abort rx", rx_log.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end
endmodule
